// File: rtl/alu_16_sequencer.sv
// 16-bit ADD/SUB/AND/OR/XOR sequencer built on a shared external 8-bit alu.
// Each operation runs a low-byte pass, a high-byte pass and, for ADD/SUB when the
// low byte carried or borrowed, a fixup pass that adds or subtracts 1 on the high byte.
// The result and Z80-style flags are registered and held until the next completion.
// Optional feature: define ALU_SEQ_ABORT_EN to add an `abort` input that cancels an
// operation while it is still in its LO/HI/FIX passes.
module alu_16_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
`ifdef ALU_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [7:0]  flags,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_flags
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpXor = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StFix,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Captured operation
  logic [15:0] a_q, b_q;
  logic [2:0]  op_q;

  // Per-pass results from the alu
  logic [7:0]  res_lo_q, res_hi_q;
  logic        c_lo_q, c_hi_q;

  // Architectural outputs
  logic [15:0] result_q;
  logic [7:0]  flags_q;
  logic        err_q;

  // Final result assembled from the pass that completes the operation
  logic [15:0] fin_result;
  logic        fin_carry;
  logic        fin_v;
  logic [7:0]  fin_flags;

  logic        abort_req;
  logic        is_arith;
  logic        accept;
  logic        illegal;
  logic        unused_alu_flags;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Only bit 0 (carry/borrow) of the alu status is meaningful here
  assign unused_alu_flags = ^alu_flags[7:1];

  assign is_arith = (op_q == OpAdd) || (op_q == OpSub);
  assign accept   = (state_q == StIdle) && start && (op <= OpXor);
  assign illegal  = (state_q == StIdle) && start && (op > OpXor);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort cancels only the working passes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLo;
        end
      end
      StLo: begin
        state_d = abort_req ? StIdle : StHi;
      end
      StHi: begin
        if (abort_req) begin
          state_d = StIdle;
        end else if (is_arith && c_lo_q) begin
          state_d = StFix;
        end else begin
          state_d = StDone;
        end
      end
      StFix: begin
        state_d = abort_req ? StIdle : StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the current state, including the alu operand mux
  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_opcode = 5'd0;
    unique case (state_q)
      StLo: begin
        alu_a      = a_q[7:0];
        alu_b      = b_q[7:0];
        alu_opcode = {2'b00, op_q};
      end
      StHi: begin
        alu_a      = a_q[15:8];
        alu_b      = b_q[15:8];
        alu_opcode = {2'b00, op_q};
      end
      StFix: begin
        // Propagate the low-byte carry/borrow into the high byte
        alu_a      = res_hi_q;
        alu_b      = 8'h01;
        alu_opcode = (op_q == OpSub) ? 5'd1 : 5'd0;
      end
      default: begin
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_opcode = 5'd0;
      end
    endcase
  end

  // Result and flags for the pass that is about to enter DONE
  always_comb begin
    fin_result = {alu_out, res_lo_q};
    // Carry out of the high byte and out of the fixup cannot both occur for one op
    fin_carry  = (state_q == StFix) ? (c_hi_q | alu_flags[0]) : alu_flags[0];
    fin_v      = 1'b0;
    if (op_q == OpAdd) begin
      fin_v = (a_q[15] == b_q[15]) && (fin_result[15] != a_q[15]);
    end else if (op_q == OpSub) begin
      fin_v = (a_q[15] != b_q[15]) && (fin_result[15] != a_q[15]);
    end
    fin_flags = {fin_result[15], (fin_result == 16'h0000), 3'b000, fin_v,
                 (op_q == OpSub), (is_arith & fin_carry)};
  end

  // Operand capture, per-pass latches, error pulse and result/flags registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      op_q     <= 3'd0;
      res_lo_q <= 8'h00;
      res_hi_q <= 8'h00;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      err_q <= illegal;
      if (accept) begin
        a_q  <= a16;
        b_q  <= b16;
        op_q <= op;
      end
      if (state_q == StLo) begin
        res_lo_q <= alu_out;
        c_lo_q   <= alu_flags[0];
      end
      if (state_q == StHi) begin
        res_hi_q <= alu_out;
        c_hi_q   <= alu_flags[0];
      end
      if (state_q == StFix) begin
        res_hi_q <= alu_out;
      end
      // Load on entry to DONE so result/flags are valid while done is high
      if ((state_d == StDone) && (state_q != StDone)) begin
        result_q <= fin_result;
        flags_q  <= fin_flags;
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign err    = err_q;

endmodule
